// File: rtl/half_adder_pkg.sv
// Shared defaults and helpers for the half_adder block and its statistics
// counters (statistics are built only with HALF_ADDER_STATS_EN defined).
package half_adder_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int CNT_W_DEFAULT = 16;

  // Adds inc to acc and clamps to the all-ones value of a cnt_w-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int          cnt_w);
    logic [63:0] max_val;
    logic [63:0] total;
    max_val = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
    total   = acc + inc;
    if ((total < acc) || (total > max_val)) begin
      return max_val;
    end
    return total;
  endfunction

endpackage

// File: rtl/half_adder_popcnt.sv
// Combinational population count of a WIDTH-bit vector.
// Feeds both the registered carry_cnt and the carry_events statistic.
module half_adder_popcnt #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]           bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/half_adder.sv
// WIDTH independent registered half-adder lanes with carry popcount.
// Optional saturating statistics counters are enabled by HALF_ADDER_STATS_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           sum,
  output logic [WIDTH-1:0]           carry,
  output logic [$clog2(WIDTH+1)-1:0] carry_cnt
`ifdef HALF_ADDER_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [CNT_W-1:0]           op_count,
  output logic [CNT_W-1:0]           carry_events
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // Reject unsupported configurations at elaboration time.
  if ((WIDTH < 1) || (WIDTH > 64) || (CNT_W < 1) || (CNT_W > 64)) begin : g_bad_params
    $error("half_adder: WIDTH must be 1..64 and CNT_W 1..64");
  end

  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] carry_next;
  logic [CW-1:0]    cnt_next;

  logic             valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] carry_reg;
  logic [CW-1:0]    cnt_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign sum_next[gi]   = a[gi] ^ b[gi];
    assign carry_next[gi] = a[gi] & b[gi];
  end

  half_adder_popcnt #(
    .WIDTH(WIDTH)
  ) u_popcnt (
    .bits (carry_next),
    .count(cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
        cnt_reg   <= cnt_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign carry_cnt = cnt_reg;

`ifdef HALF_ADDER_STATS_EN
  logic [CNT_W-1:0] op_count_reg;
  logic [CNT_W-1:0] carry_events_reg;

  // Clear wins over a same-cycle accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg     <= '0;
      carry_events_reg <= '0;
    end else if (stats_clr) begin
      op_count_reg     <= '0;
      carry_events_reg <= '0;
    end else if (in_valid) begin
      op_count_reg     <= CNT_W'(sat_add(64'(op_count_reg), 64'd1, CNT_W));
      carry_events_reg <= CNT_W'(sat_add(64'(carry_events_reg), 64'(cnt_next), CNT_W));
    end
  end

  assign op_count     = op_count_reg;
  assign carry_events = carry_events_reg;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed-vector bench for half_adder: a 1-lane and an 8-lane instance,
// plus counter checks when HALF_ADDER_STATS_EN is defined.
module tb_half_adder;

  logic       clk;
  logic       rst_n;
  logic       v1, v8;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic       ov1, ov8;
  logic [0:0] s1, c1;
  logic [0:0] n1;
  logic [7:0] s8, c8;
  logic [3:0] n8;

`ifdef HALF_ADDER_STATS_EN
  logic       clr1;
  logic [3:0] op1, ce1, op8, ce8;
`endif

  int checks = 0;
  int errors = 0;

  half_adder #(.WIDTH(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
    .out_valid(ov1), .sum(s1), .carry(c1), .carry_cnt(n1)
`ifdef HALF_ADDER_STATS_EN
    , .stats_clr(clr1), .op_count(op1), .carry_events(ce1)
`endif
  );

  half_adder #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
    .out_valid(ov8), .sum(s8), .carry(c8), .carry_cnt(n8)
`ifdef HALF_ADDER_STATS_EN
    , .stats_clr(1'b0), .op_count(op8), .carry_events(ce8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed vectors
  logic       t1a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       t1b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       e1s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       e1c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] t8a [4] = '{8'hFF, 8'hA5, 8'hFF, 8'hC3};
  logic [7:0] t8b [4] = '{8'h0F, 8'h5A, 8'hFF, 8'h81};
  logic [7:0] e8s [4] = '{8'hF0, 8'hFF, 8'h00, 8'h42};
  logic [7:0] e8c [4] = '{8'h0F, 8'h00, 8'hFF, 8'h81};
  logic [3:0] e8n [4] = '{4'd4, 4'd0, 4'd8, 4'd2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0;
    v8 = 1'b0; a8 = '0; b8 = '0;
`ifdef HALF_ADDER_STATS_EN
    clr1 = 1'b0;
`endif
    #3;
    check("rst1_valid", 64'(ov1), 64'd0);
    check("rst1_sum",   64'(s1),  64'd0);
    check("rst1_carry", 64'(c1),  64'd0);
    check("rst1_cnt",   64'(n1),  64'd0);
    check("rst8_valid", 64'(ov8), 64'd0);
    check("rst8_sum",   64'(s8),  64'd0);
    check("rst8_carry", 64'(c8),  64'd0);
    check("rst8_cnt",   64'(n8),  64'd0);
`ifdef HALF_ADDER_STATS_EN
    check("rst_op",  64'(op1), 64'd0);
    check("rst_ce",  64'(ce1), 64'd0);
    check("rst_op8", 64'(op8), 64'd0);
    check("rst_ce8", 64'(ce8), 64'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back valid vectors on both instances
    for (int i = 0; i < 4; i++) begin
      v1 = 1'b1; a1 = t1a[i]; b1 = t1b[i];
      v8 = 1'b1; a8 = t8a[i]; b8 = t8b[i];
      @(posedge clk); #1;
      check($sformatf("vec1[%0d]_valid", i), 64'(ov1), 64'd1);
      check($sformatf("vec1[%0d]_sum", i),   64'(s1),  64'(e1s[i]));
      check($sformatf("vec1[%0d]_carry", i), 64'(c1),  64'(e1c[i]));
      check($sformatf("vec1[%0d]_cnt", i),   64'(n1),  64'(e1c[i]));
      check($sformatf("vec8[%0d]_valid", i), 64'(ov8), 64'd1);
      check($sformatf("vec8[%0d]_sum", i),   64'(s8),  64'(e8s[i]));
      check($sformatf("vec8[%0d]_carry", i), 64'(c8),  64'(e8c[i]));
      check($sformatf("vec8[%0d]_cnt", i),   64'(n8),  64'(e8n[i]));
    end

    // Idle with random operands: previous results hold
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      check($sformatf("hold[%0d]_valid1", i), 64'(ov1), 64'd0);
      check($sformatf("hold[%0d]_sum1", i),   64'(s1),  64'd0);
      check($sformatf("hold[%0d]_carry1", i), 64'(c1),  64'd1);
      check($sformatf("hold[%0d]_cnt1", i),   64'(n1),  64'd1);
      check($sformatf("hold[%0d]_valid8", i), 64'(ov8), 64'd0);
      check($sformatf("hold[%0d]_sum8", i),   64'(s8),  64'h42);
      check($sformatf("hold[%0d]_carry8", i), 64'(c8),  64'h81);
    end

    // Asynchronous reset between edges while a result is valid
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(ov1), 64'd1);
    check("pre_rst_sum",   64'(s1),  64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid1", 64'(ov1), 64'd0);
    check("async_rst_sum1",   64'(s1),  64'd0);
    check("async_rst_carry1", 64'(c1),  64'd0);
    check("async_rst_sum8",   64'(s8),  64'd0);
    check("async_rst_carry8", 64'(c8),  64'd0);
    check("async_rst_cnt8",   64'(n8),  64'd0);
    v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(ov1), 64'd1);
    check("post_rst_sum",   64'(s1),  64'd1);
    check("post_rst_carry", 64'(c1),  64'd0);

`ifdef HALF_ADDER_STATS_EN
    check("stats_after_one_op", 64'(op1), 64'd1);
    check("stats_after_one_ce", 64'(ce1), 64'd0);
    a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    check("stats_sat_op", 64'(op1), 64'hF);
    check("stats_sat_ce", 64'(ce1), 64'hF);
    clr1 = 1'b1;
    @(posedge clk); #1;
    check("stats_clr_op", 64'(op1), 64'd0);
    check("stats_clr_ce", 64'(ce1), 64'd0);
    clr1 = 1'b0;
`endif
    v1 = 1'b0;
    v8 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1, sets the number of independent half-adder lanes (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, sets the width of the statistics counters (used only when HALF_ADDER_STATS_EN is defined).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  qualifies a and b this cycle.
REQ-007 Port a  input  WIDTH  addend A; lane i is a[i].
REQ-008 Port b  input  WIDTH  addend B; lane i is b[i].
REQ-009 Port out_valid  output  1  sum, carry and carry_cnt hold a new result.
REQ-010 Port sum  output  WIDTH  registered per-lane sum.
REQ-011 Port carry  output  WIDTH  registered per-lane carry.
REQ-012 Port carry_cnt  output  $clog2(WIDTH+1)  number of set bits in carry.
REQ-013 Ports stats_clr (input, 1), op_count (output, CNT_W) and carry_events (output, CNT_W) SHALL exist only when HALF_ADDER_STATS_EN is defined.

Function
REQ-014 On each rising clk edge with in_valid=1, the block SHALL register sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i] for every lane.
REQ-015 Latency SHALL be exactly one cycle: out_valid is high in the cycle after in_valid is sampled high and low otherwise.
REQ-016 When in_valid=0, sum, carry and carry_cnt SHALL hold their previous values and out_valid SHALL be 0.
REQ-017 carry_cnt SHALL be registered together with carry and always equal the popcount of the carry output.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back results with no bubbles; there is no backpressure.
REQ-019 The result SHALL be purely combinational per lane: no carry propagates between lanes.

Reset
REQ-020 While rst_n=0, out_valid, sum, carry and carry_cnt SHALL be 0 immediately, independent of clk.
REQ-021 A reset asserted mid-stream SHALL discard any in-flight result; the first valid input after deassertion SHALL appear on the following edge.
REQ-022 With HALF_ADDER_STATS_EN defined, op_count and carry_events SHALL also reset to 0.

Configuration
REQ-023 Macro HALF_ADDER_STATS_EN, when defined, SHALL add the following statistics counters:
  - op_count increments on each accepted input.
  - carry_events adds the popcount of the newly computed carry on each accepted input.
  - Both counters saturate at all-ones.
  - stats_clr=1 synchronously clears both counters and has priority over any increment in the same cycle.
REQ-024 Without HALF_ADDER_STATS_EN, the block SHALL contain no counter logic and the statistics ports SHALL be absent.

Structure
REQ-025 Package half_adder_pkg SHALL hold the WIDTH and CNT_W default constants and a saturating-add function for the counters.
REQ-026 Popcount SHALL be a separate sub-module, half_adder_popcnt, parameterized by WIDTH; it is shared by carry_cnt and carry_events.

Verification
REQ-027 With WIDTH=1, apply (a,b) = 00, 01, 10, 11 with in_valid=1 on consecutive cycles -> (sum,carry) = 00, 10, 10, 01 one cycle later, with out_valid=1 on each result.
REQ-028 With WIDTH=8, a=8'hFF, b=8'h0F, in_valid=1 -> next cycle sum=8'hF0, carry=8'h0F, carry_cnt=4.
REQ-029 Drive a valid 11, then hold in_valid=0 with random a and b for 3 cycles -> sum=0 and carry=1 are held, out_valid=0.
REQ-030 Assert rst_n=0 between clock edges while out_valid=1 -> all outputs are 0 immediately; release reset and drive a=1, b=0 valid -> sum=1 on the next edge.
REQ-031 With HALF_ADDER_STATS_EN, CNT_W=4, drive 20 valid 11 inputs -> op_count and carry_events saturate at 4'hF; then stats_clr=1 together with in_valid=1 -> both counters read 0 on the next cycle.
